// File: rtl/mci_intr_aggregator.sv
// rtl/mci_intr_aggregator.sv - MCI event aggregator: sticky status, saturating counters, err/notif irqs
// One mci_intr_path per interrupt class; the two classes never interact.

module mci_intr_path #(
  parameter int N  = 4,
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    evt,
  input  logic [N-1:0]    trig,
  input  logic [N-1:0]    w1c,
  input  logic [N-1:0]    en,
  input  logic            global_en,
  input  logic [N-1:0]    cnt_clr,
  output logic [N-1:0]    sts,
  output logic [N*CW-1:0] cnt,
  output logic            irq
);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N-1:0] hit;
  assign hit = evt | trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts <= '0;
      cnt <= '0;
      irq <= 1'b0;
    end else begin
      // irq follows the registered status, giving hit -> sts -> irq over two cycles
      irq <= global_en & |(sts & en);
      for (int i = 0; i < N; i++) begin
        if (hit[i])
          sts[i] <= 1'b1;
        else if (w1c[i])
          sts[i] <= 1'b0;

        // a clear coinciding with an event keeps that event in the count
        if (cnt_clr[i])
          cnt[i*CW +: CW] <= hit[i] ? CNT_ONE : '0;
        else if (hit[i] && cnt[i*CW +: CW] != CNT_MAX)
          cnt[i*CW +: CW] <= cnt[i*CW +: CW] + CNT_ONE;
      end
    end
  end
endmodule

module mci_intr_aggregator #(
  parameter int NUM_ERR_SRC   = 4,
  parameter int NUM_NOTIF_SRC = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             mci_rst_b,
  input  logic [NUM_ERR_SRC-1:0]           err_evt_i,
  input  logic [NUM_NOTIF_SRC-1:0]         notif_evt_i,
  input  logic [NUM_ERR_SRC-1:0]           err_trig_i,
  input  logic [NUM_NOTIF_SRC-1:0]         notif_trig_i,
  input  logic [NUM_ERR_SRC-1:0]           err_sts_w1c_i,
  input  logic [NUM_NOTIF_SRC-1:0]         notif_sts_w1c_i,
  input  logic [NUM_ERR_SRC-1:0]           err_en_i,
  input  logic [NUM_NOTIF_SRC-1:0]         notif_en_i,
  input  logic                             global_err_en_i,
  input  logic                             global_notif_en_i,
  input  logic [NUM_ERR_SRC-1:0]           err_cnt_clr_i,
  input  logic [NUM_NOTIF_SRC-1:0]         notif_cnt_clr_i,
  output logic [NUM_ERR_SRC-1:0]           err_sts_o,
  output logic [NUM_NOTIF_SRC-1:0]         notif_sts_o,
  output logic [NUM_ERR_SRC*CNT_WIDTH-1:0] err_cnt_o,
  output logic [NUM_NOTIF_SRC*CNT_WIDTH-1:0] notif_cnt_o,
  output logic                             err_irq_o,
  output logic                             notif_irq_o
);
  mci_intr_path #(.N(NUM_ERR_SRC), .CW(CNT_WIDTH)) u_err (
    .clk       (clk),
    .rst_n     (mci_rst_b),
    .evt       (err_evt_i),
    .trig      (err_trig_i),
    .w1c       (err_sts_w1c_i),
    .en        (err_en_i),
    .global_en (global_err_en_i),
    .cnt_clr   (err_cnt_clr_i),
    .sts       (err_sts_o),
    .cnt       (err_cnt_o),
    .irq       (err_irq_o)
  );

  mci_intr_path #(.N(NUM_NOTIF_SRC), .CW(CNT_WIDTH)) u_notif (
    .clk       (clk),
    .rst_n     (mci_rst_b),
    .evt       (notif_evt_i),
    .trig      (notif_trig_i),
    .w1c       (notif_sts_w1c_i),
    .en        (notif_en_i),
    .global_en (global_notif_en_i),
    .cnt_clr   (notif_cnt_clr_i),
    .sts       (notif_sts_o),
    .cnt       (notif_cnt_o),
    .irq       (notif_irq_o)
  );
endmodule

// File: tb/tb_mci_intr_aggregator.sv
// tb/tb_mci_intr_aggregator.sv - randomized model-checked bench for mci_intr_aggregator
// Built with CNT_WIDTH=4 so saturation is reachable; directed steps pin the model first.

module tb_mci_intr_aggregator;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic mci_rst_b = 1'b0;
  logic [N-1:0] err_evt, notif_evt, err_trig, notif_trig, err_w1c, notif_w1c;
  logic [N-1:0] err_en, notif_en, err_clr, notif_clr;
  logic g_err_en, g_notif_en;
  logic [N-1:0] err_sts, notif_sts;
  logic [N*CW-1:0] err_cnt, notif_cnt;
  logic err_irq, notif_irq;

  int passed = 0;
  int total = 0;

  // behavioural state: index 0 = err class, 1 = notif class
  logic [N-1:0] m_sts [2];
  int unsigned  m_cnt [2][N];
  logic         m_irq [2];

  always #5 clk = ~clk;

  mci_intr_aggregator #(.NUM_ERR_SRC(N), .NUM_NOTIF_SRC(N), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .mci_rst_b         (mci_rst_b),
    .err_evt_i         (err_evt),
    .notif_evt_i       (notif_evt),
    .err_trig_i        (err_trig),
    .notif_trig_i      (notif_trig),
    .err_sts_w1c_i     (err_w1c),
    .notif_sts_w1c_i   (notif_w1c),
    .err_en_i          (err_en),
    .notif_en_i        (notif_en),
    .global_err_en_i   (g_err_en),
    .global_notif_en_i (g_notif_en),
    .err_cnt_clr_i     (err_clr),
    .notif_cnt_clr_i   (notif_clr),
    .err_sts_o         (err_sts),
    .notif_sts_o       (notif_sts),
    .err_cnt_o         (err_cnt),
    .notif_cnt_o       (notif_cnt),
    .err_irq_o         (err_irq),
    .notif_irq_o       (notif_irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_sts[p] = '0;
      m_irq[p] = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[p][i] = 0;
    end
  endtask

  task automatic step_path(input int p, input logic [N-1:0] evt, input logic [N-1:0] trig,
                           input logic [N-1:0] w1c, input logic [N-1:0] clr,
                           input logic [N-1:0] en, input logic gen);
    logic h;
    m_irq[p] = gen && ((m_sts[p] & en) != '0);
    for (int i = 0; i < N; i++) begin
      h = evt[i] | trig[i];
      if (h) m_sts[p][i] = 1'b1;
      else if (w1c[i]) m_sts[p][i] = 1'b0;
      if (clr[i]) m_cnt[p][i] = h ? 1 : 0;
      else if (h && m_cnt[p][i] < CMAX) m_cnt[p][i]++;
    end
  endtask

  task automatic compare_all();
    chk("err_sts", 64'(err_sts), 64'(m_sts[0]));
    chk("notif_sts", 64'(notif_sts), 64'(m_sts[1]));
    chk("err_irq", 64'(err_irq), 64'(m_irq[0]));
    chk("notif_irq", 64'(notif_irq), 64'(m_irq[1]));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("err_cnt%0d", i), 64'(err_cnt[i*CW +: CW]), 64'(m_cnt[0][i]));
      chk($sformatf("notif_cnt%0d", i), 64'(notif_cnt[i*CW +: CW]), 64'(m_cnt[1][i]));
    end
  endtask

  task automatic clear_pulses();
    err_evt = '0; notif_evt = '0; err_trig = '0; notif_trig = '0;
    err_w1c = '0; notif_w1c = '0; err_clr = '0; notif_clr = '0;
  endtask

  // called at a negedge with inputs already set; returns at the next negedge
  task automatic tick();
    @(posedge clk);
    if (mci_rst_b) begin
      step_path(0, err_evt, err_trig, err_w1c, err_clr, err_en, g_err_en);
      step_path(1, notif_evt, notif_trig, notif_w1c, notif_clr, notif_en, g_notif_en);
    end
    #1 compare_all();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic async_reset();
    mci_rst_b = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    mci_rst_b = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_pulses();
    err_en = '0; notif_en = '0; g_err_en = 1'b0; g_notif_en = 1'b0;
    model_reset();
    #3;
    chk("rst_err_sts", 64'(err_sts), 64'h0);
    chk("rst_err_irq", 64'(err_irq), 64'h0);
    chk("rst_err_cnt", 64'(err_cnt), 64'h0);
    chk("rst_notif_cnt", 64'(notif_cnt), 64'h0);
    @(negedge clk);
    mci_rst_b = 1'b1;

    // basic event -> sts -> irq
    err_en = 4'b0001; g_err_en = 1'b1;
    err_evt[0] = 1'b1; tick();
    chk("lit_sts_n1", 64'(err_sts), 64'h1);
    chk("lit_irq_n1", 64'(err_irq), 64'h0);
    chk("lit_cnt0", 64'(err_cnt[0 +: CW]), 64'h1);
    tick();
    chk("lit_irq_n2", 64'(err_irq), 64'h1);
    err_w1c[0] = 1'b1; tick();
    chk("lit_w1c_sts", 64'(err_sts), 64'h0);
    chk("lit_w1c_irq_hold", 64'(err_irq), 64'h1);
    tick();
    chk("lit_w1c_irq_drop", 64'(err_irq), 64'h0);

    // set wins over w1c; evt+trig counts once
    err_evt[1] = 1'b1; tick();
    err_evt[1] = 1'b1; err_w1c[1] = 1'b1; tick();
    chk("lit_setwins_sts", 64'(err_sts[1]), 64'h1);
    chk("lit_setwins_cnt", 64'(err_cnt[CW +: CW]), 64'h2);
    err_evt[1] = 1'b1; err_trig[1] = 1'b1; tick();
    chk("lit_evt_trig_once", 64'(err_cnt[CW +: CW]), 64'h3);

    // masked notif event, then enable
    g_notif_en = 1'b1; notif_en = '0;
    notif_evt[0] = 1'b1; tick();
    chk("lit_masked_sts", 64'(notif_sts), 64'h1);
    tick();
    chk("lit_masked_irq", 64'(notif_irq), 64'h0);
    notif_en = 4'b0001; tick();
    chk("lit_unmask_irq", 64'(notif_irq), 64'h1);

    // saturation and clear priority
    for (int k = 0; k < 20; k++) begin err_evt[2] = 1'b1; tick(); end
    chk("lit_sat", 64'(err_cnt[2*CW +: CW]), 64'hF);
    err_evt[2] = 1'b1; err_clr[2] = 1'b1; tick();
    chk("lit_clr_evt", 64'(err_cnt[2*CW +: CW]), 64'h1);
    err_clr[2] = 1'b1; tick();
    chk("lit_clr_only", 64'(err_cnt[2*CW +: CW]), 64'h0);

    // mid-stream reset with sts=1011, cnt0=7, irq=1
    err_w1c = '1; err_clr = '1; err_en = '1; tick();
    for (int k = 0; k < 7; k++) begin err_evt = 4'b1011; tick(); end
    chk("lit_pre_rst_sts", 64'(err_sts), 64'hB);
    chk("lit_pre_rst_cnt", 64'(err_cnt[0 +: CW]), 64'h7);
    chk("lit_pre_rst_irq", 64'(err_irq), 64'h1);
    #2 async_reset();
    chk("lit_rst_all", 64'({err_sts, notif_sts, err_cnt, notif_cnt, err_irq, notif_irq}), 64'h0);
    tick(); tick();
    chk("lit_post_rst_irq", 64'(err_irq), 64'h0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      err_evt    = 4'($urandom & $urandom & $urandom);
      notif_evt  = 4'($urandom & $urandom & $urandom);
      err_trig   = 4'($urandom & $urandom & $urandom & $urandom);
      notif_trig = 4'($urandom & $urandom & $urandom & $urandom);
      err_w1c    = 4'($urandom & $urandom & $urandom);
      notif_w1c  = 4'($urandom & $urandom & $urandom);
      err_clr    = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      notif_clr  = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(15) == 0) err_en = 4'($urandom);
      if ($urandom_range(15) == 0) notif_en = 4'($urandom);
      if ($urandom_range(31) == 0) g_err_en = ~g_err_en;
      if ($urandom_range(31) == 0) g_notif_en = ~g_notif_en;
      if ($urandom_range(499) == 0) begin
        #($urandom_range(4)) async_reset();
        clear_pulses();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
